mac_reg_arbiter: RTL and testbench

MAC_REG_ARBITER -- requirements
Module: mac_reg_arbiter

---
 rtl/mac_reg_pkg.sv | 18 +
 rtl/mac_reg_timeout.sv | 36 +++
 rtl/mac_reg_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mac_reg_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_reg_pkg.sv
// Shared types and constants for the MAC register-bus arbiter and its timeout counter.
package mac_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StDone
  } arb_state_e;

  localparam logic REQ_INIT = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Read data returned on a timed-out access; sliced to the bus width at use.
  localparam int unsigned TmoPatternW = 256;
  localparam logic [TmoPatternW-1:0] TMO_RDATA = '1;

endpackage

// File: rtl/mac_reg_timeout.sv
// Busy-wait watchdog for the MAC register arbiter: counts enabled cycles, flags expiry.
module mac_reg_timeout #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LastCnt = 16'(CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // High during the last allowed wait cycle, so the FSM leaves exactly CYCLES after entry.
  assign expired = enable && (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_reg_arbiter.sv
// Two-requester arbiter (init sequencer, host CSR) onto a busy-handshaked MAC register bus.
// Optional busy-wait timeout enabled by defining MAC_ARB_TIMEOUT_EN.
module mac_reg_arbiter
  import mac_reg_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic              init_done,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_writedata,
  output logic              reg_rd,
  output logic              reg_wr,
  input  logic [DATA_W-1:0] reg_readdata,
  input  logic              reg_busy,
  output logic              tmo_err,
  output logic              gnt_id
);

  if ((TMO_CYCLES < 2) || (TMO_CYCLES > 65535)) begin : g_tmo_range
    $error("mac_reg_arbiter: TMO_CYCLES must be within 2..65535");
  end

  arb_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              tmo_err_q, tmo_err_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              tmo_expired;

  logic              r1_elig, any_req, pick_host, sel_wr;
  logic              finish, cap_en, tmo_hit;
  logic [DATA_W-1:0] cap_data;

  `ifdef MAC_ARB_TIMEOUT_EN
  logic tmo_en, tmo_clr;
  assign tmo_en  = (state_q == StIssue) || (state_q == StBusy);
  assign tmo_clr = (state_q == StIdle);

  mac_reg_timeout #(
    .CYCLES(TMO_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (tmo_en),
    .clear  (tmo_clr),
    .expired(tmo_expired)
  );
  `else
  assign tmo_expired = 1'b0;
  `endif

  // Host is only eligible once init has finished; on contention the last winner yields.
  assign r1_elig   = r1_req & init_done;
  assign any_req   = r0_req | r1_elig;
  assign pick_host = r1_elig & (~r0_req | (last_q == REQ_INIT));
  assign sel_wr    = pick_host ? r1_wr : r0_wr;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_stb_d  = rd_stb_q;
    wr_stb_d  = wr_stb_q;
    ack0_d    = ack0_q;
    ack1_d    = ack1_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    tmo_err_d = tmo_err_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    finish    = 1'b0;
    cap_en    = 1'b0;
    tmo_hit   = 1'b0;
    cap_data  = reg_readdata;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StIssue;
          gnt_d    = pick_host ? REQ_HOST : REQ_INIT;
          last_d   = pick_host ? REQ_HOST : REQ_INIT;
          wr_d     = sel_wr;
          addr_d   = pick_host ? r1_addr : r0_addr;
          wdata_d  = pick_host ? r1_wdata : r0_wdata;
          wr_stb_d = sel_wr;
          rd_stb_d = ~sel_wr;
        end
      end
      StIssue: begin
        if (tmo_expired) begin
          tmo_hit = 1'b1;
        end else if (reg_busy) begin
          state_d  = StBusy;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
        end
      end
      StBusy: begin
        if (tmo_expired) begin
          tmo_hit = 1'b1;
        end else if (!reg_busy) begin
          finish = 1'b1;
          cap_en = ~wr_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (tmo_hit) begin
      finish    = 1'b1;
      cap_en    = 1'b1;
      cap_data  = TMO_RDATA[DATA_W-1:0];
      tmo_err_d = 1'b1;
    end

    if (finish) begin
      state_d  = StDone;
      rd_stb_d = 1'b0;
      wr_stb_d = 1'b0;
      if (gnt_q == REQ_HOST) begin
        ack1_d = 1'b1;
        if (cap_en) rdata1_d = cap_data;
      end else begin
        ack0_d = 1'b1;
        if (cap_en) rdata0_d = cap_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      tmo_err_q <= 1'b0;
      gnt_q     <= REQ_INIT;
      last_q    <= REQ_HOST;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      tmo_err_q <= tmo_err_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
    end
  end

  assign reg_addr      = addr_q;
  assign reg_writedata = wdata_q;
  assign reg_rd        = rd_stb_q;
  assign reg_wr        = wr_stb_q;
  assign r0_ack        = ack0_q;
  assign r1_ack        = ack1_q;
  assign r0_rdata      = rdata0_q;
  assign r1_rdata      = rdata1_q;
  assign tmo_err       = tmo_err_q;
  assign gnt_id        = gnt_q;

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Scoreboard bench for mac_reg_arbiter: directed accesses against a small MAC register model.
module tb_mac_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r0_wr = 1'b0, r1_req = 1'b0, r1_wr = 1'b0;
  logic [7:0]  r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_ack, r1_ack;
  logic [31:0] r0_rdata, r1_rdata;
  logic        init_done = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] reg_writedata;
  logic        reg_rd, reg_wr;
  logic [31:0] reg_readdata = '0;
  logic        reg_busy = 1'b0;
  logic        tmo_err, gnt_id;

  mac_reg_arbiter #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .TMO_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_req       (r0_req),
    .r0_wr        (r0_wr),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_ack       (r0_ack),
    .r0_rdata     (r0_rdata),
    .r1_req       (r1_req),
    .r1_wr        (r1_wr),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_ack       (r1_ack),
    .r1_rdata     (r1_rdata),
    .init_done    (init_done),
    .reg_addr     (reg_addr),
    .reg_writedata(reg_writedata),
    .reg_rd       (reg_rd),
    .reg_wr       (reg_wr),
    .reg_readdata (reg_readdata),
    .reg_busy     (reg_busy),
    .tmo_err      (tmo_err),
    .gnt_id       (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  int          ack0_cnt = 0, ack1_cnt = 0;
  logic        strobe_fault = 1'b0, ack_fault = 1'b0;

  // MAC register model
  logic [31:0] dev_mem [0:255];
  int          busy_len = 1, dev_cnt = 0, dev_strobes = 0, dev_wr_cnt = 0;
  logic        dev_stuck = 1'b0;
  logic [31:0] dev_pend = '0, last_wdata = '0;
  logic [7:0]  last_waddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic id, input logic is_rd, input logic [31:0] d);
    exp_t e;
    if (is_rd) begin
      if (id) exp_rd1 = d;
      else    exp_rd0 = d;
    end
    e.id    = id;
    e.rdata = id ? exp_rd1 : exp_rd0;
    exp_q.push_back(e);
  endtask

  // Wait for n acks within budget cycles, then withdraw both requests.
  task automatic serve(input int n, input int budget, output int ack_cyc);
    int cnt = 0;
    ack_cyc = 0;
    for (int c = 0; c < budget && cnt < n; c++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        cnt++;
        ack_cyc = cyc;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    check("serve_ack_count", 32'(cnt), 32'(n));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < 256; i++) dev_mem[i] = 32'h0;
    dev_mem[2] = 32'h0000_2222;
    dev_mem[3] = 32'h3333_0003;
    dev_mem[4] = 32'h4444_0004;
    dev_mem[5] = 32'h5555_0005;
    dev_mem[9] = 32'd500;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        dev_cnt  = 0;
        reg_busy = 1'b0;
        continue;
      end
      reg_readdata = 32'hBAD0_BAD0;
      if (dev_cnt > 0) begin
        if (!dev_stuck) begin
          dev_cnt--;
          if (dev_cnt == 0) begin
            reg_busy     = 1'b0;
            reg_readdata = dev_pend;
          end
        end
      end else if ((reg_rd || reg_wr) && !reg_busy) begin
        dev_strobes++;
        if (reg_wr) begin
          dev_mem[reg_addr] = reg_writedata;
          last_waddr        = reg_addr;
          last_wdata        = reg_writedata;
          dev_wr_cnt++;
        end else begin
          dev_pend = dev_mem[reg_addr];
        end
        reg_busy = 1'b1;
        dev_cnt  = busy_len;
      end
    end
  end

  // Monitor: pops one expectation per ack.
  initial begin
    logic prev_ack = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 1'b0;
        continue;
      end
      if (reg_rd && reg_wr) strobe_fault = 1'b1;
      if (r0_ack && r1_ack) ack_fault = 1'b1;
      if ((r0_ack || r1_ack) && prev_ack) ack_fault = 1'b1;
      prev_ack = r0_ack | r1_ack;
      if (r0_ack || r1_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_id", {31'd0, r1_ack}, {31'd0, e.id});
          check("gnt_id", {31'd0, gnt_id}, {31'd0, e.id});
          check("ack_rdata", r1_ack ? r1_rdata : r0_rdata, e.rdata);
          if (r1_ack) ack1_cnt++;
          else        ack0_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, ack_cyc, s0, a0, a1;
    logic seen;

    repeat (3) @(negedge clk);
    check("rst_strobes", {28'd0, reg_rd, reg_wr, r0_ack, r1_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_addr", {24'd0, reg_addr}, 32'd0);
    check("reset_wdata", reg_writedata, 32'd0);
    check("reset_rdata", r0_rdata | r1_rdata, 32'd0);
    check("reset_flags", {30'd0, tmo_err, gnt_id}, 32'd0);

    // Init-phase write by r0
    busy_len = 2;
    push_exp(1'b0, 1'b0, 32'd0);
    r0_wr = 1'b1; r0_addr = 8'd3; r0_wdata = 32'h0615_0910; r0_req = 1'b1;
    serve(1, 40, ack_cyc);
    check("wr_count", 32'(dev_wr_cnt), 32'd1);
    check("wr_addr", {24'd0, last_waddr}, 32'd3);
    check("wr_data", last_wdata, 32'h0615_0910);

    // Host blocked until init_done
    r1_wr = 1'b0; r1_addr = 8'd2; r1_req = 1'b1;
    s0 = dev_strobes;
    repeat (50) @(negedge clk);
    check("blocked_no_strobe", 32'(dev_strobes), 32'(s0));
    push_exp(1'b1, 1'b1, 32'h0000_2222);
    k = cyc;
    init_done = 1'b1;
    serve(1, 40, ack_cyc);
    check("unblock_latency_ok", {31'd0, (ack_cyc - k) <= 4 + busy_len}, 32'd1);

    // Fairness: both requesting for 20 accesses, r0 first after a host grant
    busy_len = 1;
    a0 = ack0_cnt; a1 = ack1_cnt;
    for (int i = 0; i < 10; i++) begin
      push_exp(1'b0, 1'b1, 32'h4444_0004);
      push_exp(1'b1, 1'b1, 32'h5555_0005);
    end
    r0_wr = 1'b0; r0_addr = 8'd4;
    r1_wr = 1'b0; r1_addr = 8'd5;
    r0_req = 1'b1; r1_req = 1'b1;
    serve(20, 200, ack_cyc);
    check("fair_r0_acks", 32'(ack0_cnt - a0), 32'd10);
    check("fair_r1_acks", 32'(ack1_cnt - a1), 32'd10);

    // Host read of 500
    push_exp(1'b1, 1'b1, 32'd500);
    r1_addr = 8'd9; r1_req = 1'b1;
    serve(1, 40, ack_cyc);

    // Write then read back through the other requester
    push_exp(1'b0, 1'b0, 32'd0);
    r0_wr = 1'b1; r0_addr = 8'd7; r0_wdata = 32'hDEAD_BEEF; r0_req = 1'b1;
    serve(1, 40, ack_cyc);
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF);
    r1_addr = 8'd7; r1_req = 1'b1;
    serve(1, 40, ack_cyc);

    // Reset while the access sits in BUSY
    busy_len = 6;
    r0_wr = 1'b0; r0_addr = 8'd3; r0_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (reg_busy && !reg_rd && !reg_wr) seen = 1'b1;
    end
    check("reached_busy", {31'd0, seen}, 32'd1);
    check("busy_addr", {24'd0, reg_addr}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_strobes", {30'd0, reg_rd, reg_wr}, 32'd0);
    check("async_rst_addr", {24'd0, reg_addr}, 32'd0);
    r0_req = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_len = 1;
    check("rst_clears_rdata", r0_rdata | r1_rdata, 32'd0);
    repeat (10) @(negedge clk);

    // Simultaneous requests after reset: r0 first
    push_exp(1'b0, 1'b1, 32'h0000_2222);
    push_exp(1'b1, 1'b1, 32'd500);
    r0_addr = 8'd2; r1_addr = 8'd9;
    r0_req = 1'b1; r1_req = 1'b1;
    serve(2, 40, ack_cyc);

`ifdef MAC_ARB_TIMEOUT_EN
    dev_stuck = 1'b1;
    push_exp(1'b0, 1'b1, 32'hFFFF_FFFF);
    r0_addr = 8'd5; r0_req = 1'b1;
    k = cyc;
    serve(1, 60, ack_cyc);
    check("tmo_latency", 32'(ack_cyc - (k + 1)), 32'd16);
    check("tmo_err_set", {31'd0, tmo_err}, 32'd1);
    dev_stuck = 1'b0;
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", {31'd0, tmo_err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("tmo_err_rst", {31'd0, tmo_err}, 32'd0);
`else
    check("tmo_err_tied", {31'd0, tmo_err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("strobe_exclusive", {31'd0, strobe_fault}, 32'd0);
    check("ack_single_pulse", {31'd0, ack_fault}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
